// File: rtl/spram_pkg.sv
// Shared types and helpers for the single-port-pair RAM arbiter.
// Round-robin pick is shared by the read and write pickers.
package spram_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int NUM_REQ_MAX = 4;

    typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_idx_t;

    // First set bit of mask at or after ptr, wrapping mod n.
    function automatic req_idx_t rr_pick(
        input logic [NUM_REQ_MAX-1:0] mask,
        input req_idx_t               ptr,
        input int                     n
    );
        req_idx_t w;
        req_idx_t jj;
        logic     found;
        int       j;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ_MAX; k++) begin
            j  = (int'(ptr) + k) % n;
            jj = req_idx_t'(j);
            if (k < n && !found && mask[jj]) begin
                w     = jj;
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester and RAM-side bundle for spram_arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface spram_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      ram_do_read;
    logic [ADDR_W-1:0]         ram_read_addr;
    logic [DATA_W-1:0]         ram_read_data;
    logic                      ram_do_write;
    logic [ADDR_W-1:0]         ram_write_addr;
    logic [DATA_W-1:0]         ram_write_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  ram_read_data,
        output req_ready, rsp_valid, rsp_data,
        output ram_do_read, ram_read_addr,
        output ram_do_write, ram_write_addr, ram_write_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output ram_read_data,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_do_read, ram_read_addr,
        input  ram_do_write, ram_write_addr, ram_write_data
    );
endinterface

// File: rtl/spram_arbiter_rr_picker.sv
// Round-robin picker: one-hot grant, index and any-grant
// for a request mask searched from ptr upward.
module rr_picker
    import spram_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] mask,
    input  req_idx_t     ptr,
    output logic [N-1:0] gnt,
    output req_idx_t     idx,
    output logic         any
);

    logic [NUM_REQ_MAX-1:0] m_wide;

    always_comb begin
        m_wide         = '0;
        m_wide[N-1:0]  = mask;
        idx            = rr_pick(m_wide, ptr, N);
        any            = |mask;
        gnt            = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (idx == req_idx_t'(i));
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Arbitrates one read and one write per cycle onto a shared RAM,
// holds back a read that collides with the granted write.
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = spram_pkg::ADDR_W,
    parameter int DATA_W  = spram_pkg::DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    spram_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0] rd_mask;
    logic [NUM_REQ-1:0] wr_mask;
    logic [NUM_REQ-1:0] rd_gnt;
    logic [NUM_REQ-1:0] wr_gnt;
    req_idx_t           rd_idx;
    req_idx_t           wr_idx;
    logic               rd_any;
    logic               wr_any;

    req_idx_t           rd_ptr_q, rd_ptr_d;
    req_idx_t           wr_ptr_q, wr_ptr_d;
    req_idx_t           rsp_idx_q, rsp_idx_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;

    logic [ADDR_W-1:0]  rd_win_addr;
    logic [ADDR_W-1:0]  wr_win_addr;
    logic [DATA_W-1:0]  wr_win_data;
    logic               collide;
    logic               rd_go;

    function automatic req_idx_t nxt(input req_idx_t p);
        if (int'(p) >= NUM_REQ - 1) return '0;
        return p + req_idx_t'(1);
    endfunction

    // Requests are invisible while reset is held.
    always_comb begin
        rd_mask = rst_n ? (bus.req_valid & ~bus.req_we) : '0;
        wr_mask = rst_n ? (bus.req_valid &  bus.req_we) : '0;
    end

    rr_picker #(.N(NUM_REQ)) u_rd_pick (
        .mask (rd_mask),
        .ptr  (rd_ptr_q),
        .gnt  (rd_gnt),
        .idx  (rd_idx),
        .any  (rd_any)
    );

    rr_picker #(.N(NUM_REQ)) u_wr_pick (
        .mask (wr_mask),
        .ptr  (wr_ptr_q),
        .gnt  (wr_gnt),
        .idx  (wr_idx),
        .any  (wr_any)
    );

    always_comb begin
        rd_win_addr = '0;
        wr_win_addr = '0;
        wr_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_idx == req_idx_t'(i))
                rd_win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            if (wr_idx == req_idx_t'(i)) begin
                wr_win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                wr_win_data = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
        // Write wins a same-address clash; the read retries next cycle.
        collide = rd_any && wr_any && (rd_win_addr == wr_win_addr);
        rd_go   = rd_any && !collide;
    end

    always_comb begin
        bus.req_ready      = wr_gnt | (rd_go ? rd_gnt : '0);
        bus.ram_do_read    = rd_go;
        bus.ram_read_addr  = rd_go ? rd_win_addr : rd_addr_q;
        bus.ram_do_write   = wr_any;
        bus.ram_write_addr = wr_any ? wr_win_addr : '0;
        bus.ram_write_data = wr_any ? wr_win_data : '0;
        bus.rsp_data       = rsp_vld_q ? bus.ram_read_data : '0;
        bus.rsp_valid      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = rsp_vld_q && (rsp_idx_q == req_idx_t'(i));
        end
    end

    always_comb begin
        rd_ptr_d  = rd_go  ? nxt(rd_idx) : rd_ptr_q;
        wr_ptr_d  = wr_any ? nxt(wr_idx) : wr_ptr_q;
        rsp_vld_d = rd_go;
        rsp_idx_d = rd_go ? rd_idx : rsp_idx_q;
        rd_addr_d = bus.ram_read_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rsp_idx_q <= '0;
            rsp_vld_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_vld_q <= rsp_vld_d;
            rd_addr_q <= rd_addr_d;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed and random checks of spram_arbiter against a
// transaction-level model of grants, collisions and RAM contents.
module tb_spram_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    spram_arbiter_if #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) bus ();

    spram_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [N-1:0] v  = '0;
    logic [N-1:0] wr = '0;
    logic [7:0]   ad [N];
    logic [7:0]   wd [N];

    always_comb begin
        bus.req_valid = v;
        bus.req_we    = wr;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*8 +: 8]  = ad[i];
            bus.req_wdata[i*8 +: 8] = wd[i];
        end
    end

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h00:   return 8'hAA;
            8'h01:   return 8'hBB;
            8'h20:   return 8'h11;
            8'h31:   return 8'h77;
            default: return a ^ 8'h3C;
        endcase
    endfunction

    // RAM instance with gated writes and a registered read port.
    logic [7:0] ram [256];
    logic [7:0] rdat;
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) ram[a] <= init_val(a[7:0]);
        end else if (bus.ram_do_write) begin
            ram[bus.ram_write_addr] <= bus.ram_write_data;
        end
        if (bus.ram_do_read) rdat <= ram[bus.ram_read_addr];
    end
    assign bus.ram_read_data = rdat;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0]   mem [256];
    int           wp, rp;
    logic [7:0]   last_ra;
    bit           pv;
    int           pidx;
    logic [7:0]   pd;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] s_rdy, s_rsp;
    logic [7:0]   s_dat;
    logic         s_rd;

    task automatic model_reset();
        wp = 0;
        rp = 0;
        last_ra = 8'h00;
        pv = 1'b0;
        pidx = 0;
        pd = 8'h00;
    endtask

    task automatic model_check();
        int ew, er, j;
        logic [N-1:0] ersp;
        ew = -1;
        er = -1;
        for (int k = 0; k < N; k++) begin
            j = (wp + k) % N;
            if (ew < 0 && v[j] && wr[j]) ew = j;
            j = (rp + k) % N;
            if (er < 0 && v[j] && !wr[j]) er = j;
        end
        if (ew >= 0 && er >= 0 && ad[er] == ad[ew]) er = -1;
        exp_rdy = '0;
        if (ew >= 0) exp_rdy[ew] = 1'b1;
        if (er >= 0) exp_rdy[er] = 1'b1;
        ersp = '0;
        if (pv) ersp[pidx] = 1'b1;

        s_rdy = bus.req_ready;
        s_rsp = bus.rsp_valid;
        s_dat = bus.rsp_data;
        s_rd  = bus.ram_do_read;

        chk("ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ersp));
        if (pv) chk("rsp_data", 32'(bus.rsp_data), 32'(pd));
        chk("do_read", 32'(bus.ram_do_read), 32'(er >= 0));
        chk("read_addr", 32'(bus.ram_read_addr),
            32'((er >= 0) ? ad[er] : last_ra));
        chk("do_write", 32'(bus.ram_do_write), 32'(ew >= 0));
        if (ew >= 0) begin
            chk("write_addr", 32'(bus.ram_write_addr), 32'(ad[ew]));
            chk("write_data", 32'(bus.ram_write_data), 32'(wd[ew]));
        end

        pv = (er >= 0);
        if (er >= 0) begin
            pidx = er;
            pd = mem[ad[er]];
            last_ra = ad[er];
            rp = (er + 1) % N;
        end
        if (ew >= 0) begin
            mem[ad[ew]] = wd[ew];
            wp = (ew + 1) % N;
        end
    endtask

    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = init_val(a[7:0]);
        for (int i = 0; i < N; i++) begin
            ad[i] = 8'h00;
            wd[i] = 8'h00;
        end
        model_reset();

        // Requests during reset must be ignored.
        v = 2'b11; wr = 2'b01; ad[0] = 8'h05; ad[1] = 8'h06; wd[0] = 8'h99;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_do_read", 32'(bus.ram_do_read), 32'h0);
        chk("rst_do_write", 32'(bus.ram_do_write), 32'h0);
        chk("rst_waddr", 32'(bus.ram_write_addr), 32'h0);
        chk("rst_wdata", 32'(bus.ram_write_data), 32'h0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; preload = 1'b0; v = '0;
        tick();
        chk("idle_rsp", 32'(s_rsp), 32'h0);

        // Write then read back from another requester.
        v = 2'b01; wr = 2'b01; ad[0] = 8'h10; wd[0] = 8'h5A;
        tick();
        chk("wr_ready", 32'(s_rdy), 32'h1);
        v = 2'b10; wr = 2'b00; ad[1] = 8'h10;
        tick();
        chk("rd_ready", 32'(s_rdy), 32'h2);
        v = 2'b00;
        tick();
        chk("rd_rsp_valid", 32'(s_rsp), 32'h2);
        chk("rd_rsp_data", 32'(s_dat), 32'h5A);

        // Two continuous readers alternate.
        wr = 2'b00; ad[0] = 8'h00; ad[1] = 8'h01;
        for (int k = 0; k < 5; k++) begin
            v = (k < 4) ? 2'b11 : 2'b00;
            tick();
            if (k < 4) chk("alt_ready", 32'(s_rdy), (k % 2) ? 32'h2 : 32'h1);
            if (k > 0) begin
                chk("alt_rsp", 32'(s_rsp), (k % 2) ? 32'h1 : 32'h2);
                chk("alt_data", 32'(s_dat), (k % 2) ? 32'hAA : 32'hBB);
            end
        end

        // Same-address collision stalls the read.
        v = 2'b11; wr = 2'b01; ad[0] = 8'h20; wd[0] = 8'h33; ad[1] = 8'h20;
        tick();
        chk("col_ready", 32'(s_rdy), 32'h1);
        chk("col_no_read", 32'(s_rd), 32'h0);
        v = 2'b10;
        tick();
        chk("col_retry", 32'(s_rdy), 32'h2);
        v = 2'b00;
        tick();
        chk("col_rsp", 32'(s_rsp), 32'h2);
        chk("col_data", 32'(s_dat), 32'h33);

        // Different addresses both proceed.
        v = 2'b11; wr = 2'b01; ad[0] = 8'h30; wd[0] = 8'h44; ad[1] = 8'h31;
        tick();
        chk("par_ready", 32'(s_rdy), 32'h3);
        v = 2'b00;
        tick();
        chk("par_data", 32'(s_dat), 32'h77);

        // Reset pulse while a read is in flight.
        v = 2'b01; wr = 2'b00; ad[0] = 8'h10;
        #1;
        model_check();
        chk("mid_ready", 32'(s_rdy), 32'h1);
        #1;
        rst_n = 1'b0; v = 2'b00;
        #1;
        chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v = 2'b11; wr = 2'b00; ad[0] = 8'h10; ad[1] = 8'h00;
        tick();
        chk("post_rst_rsp", 32'(s_rsp), 32'h0);
        chk("post_rst_ptr", 32'(s_rdy), 32'h1);
        v = 2'b10;
        tick();
        chk("kept_rsp", 32'(s_rsp), 32'h1);
        chk("kept_data", 32'(s_dat), 32'h5A);
        v = 2'b00;
        tick();
        chk("kept_rsp1", 32'(s_dat), 32'hAA);

        // Random traffic on a small address window to force clashes.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i]) v[i] = 1'b0;
                if (!v[i] && $urandom_range(0, 3) != 0) begin
                    v[i]  = 1'b1;
                    wr[i] = 1'($urandom_range(0, 1));
                    ad[i] = 8'(8'h40 + $urandom_range(0, 5));
                    wd[i] = 8'($urandom);
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one 256x8 synchronous RAM (separate read and write ports, 1-cycle registered read) between NUM_REQ requesters, e.g. CPU core and DMA/loader.
- Each cycle it grants at most one read and at most one write, each chosen by its own round-robin pointer.
- It detects same-address read/write collisions and returns read data to the requester that issued the read.
- It sits between the requesters and the RAM instance and is the only block that drives the RAM ports.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_ready  out  NUM_REQ  request accepted this cycle (combinational grant).
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_data  out  DATA_W  read data; shared by all requesters and qualified by rsp_valid.
- ram_do_read  out  1  RAM read enable.
- ram_read_addr  out  ADDR_W  RAM read address.
- ram_read_data  in  DATA_W  RAM registered read data.
- ram_do_write  out  1  RAM write enable.
- ram_write_addr  out  ADDR_W  RAM write address.
- ram_write_data  out  DATA_W  RAM write data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr = 0, wr_ptr = 0.
  - rsp_valid = 0, the pending-read registers are cleared, ram_do_read = 0, ram_do_write = 0.
  - ram_write_addr and ram_write_data drive 0.
  - All requests are ignored while rst_n is low.
- RAM contract: the RAM instance must gate writes with ram_do_write. Writing on every cycle is not permitted with this arbiter.
- Handshake: a request transfers when req_valid[i] and req_ready[i] are both high in the same cycle. The requester holds valid, we, addr and wdata stable until ready. req_ready never asserts without req_valid.
- Write arbitration, combinational within the cycle:
  - Candidates are requesters with valid=1 and we=1.
  - The winner is the first candidate found starting at wr_ptr, with index wrapping mod NUM_REQ.
  - For the winner: ram_do_write=1, address and data are forwarded, and req_ready is asserted.
  - On the clock edge, wr_ptr <= winner+1 mod NUM_REQ. The pointer is unchanged if there is no grant.
- Read arbitration works the same way: candidates have valid=1 and we=0, the search starts at rd_ptr, and ram_do_read=1 is asserted for the winner.
- Read latency:
  - A read granted in cycle T gives rsp_valid[winner]=1 in cycle T+1, with rsp_data = ram_read_data.
  - The registered state is the winner index plus a valid bit.
  - At most one rsp_valid bit is high per cycle. There is no response backpressure; requesters must sink the data.
  - Writes produce no response; req_ready is the completion.
- Collision: if the read winner's address equals the write winner's address in the same cycle, the write is granted and the read is held back (its req_ready stays 0).
  - rd_ptr does not advance.
  - The read is re-arbitrated next cycle and returns the newly written data.
  - No other reader is substituted into the held cycle.
- The same requester cannot be both the read and the write winner, because its we bit selects one class.
- Back-to-back: a requester may issue a new read in T+1 while its response from T is being delivered. Throughput is one read plus one write per cycle.
- Idle cycles: ram_do_read=0 and ram_do_write=0. ram_read_addr holds its last value; the don't-care is resolved to hold.
- Reset mid-read: if a read was granted in T and rst_n is asserted before T+1, the response is discarded and rsp_valid stays 0.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles of its own class. A reader blocked by a collision is granted within NUM_REQ+1 cycles, provided the same write address is not repeated indefinitely.

Decomposition:
- Shared package spram_pkg holds:
  - ADDR_W and DATA_W constants.
  - A req_idx_t typedef sized clog2(NUM_REQ_MAX=4).
  - The rr_pick function signature.
- One sub-module, rr_picker: inputs request mask and pointer; outputs one-hot grant, winner index and any-grant. It is instantiated twice, once for reads and once for writes.
- Top level keeps the pointers, the collision compare, and the read-response pipeline register.

Test Plan:
- Reset, then idle: all outputs 0, no RAM enables; releasing rst_n with no valids keeps rsp_valid=0.
- Req0 writes 0x5A to 0x10 (accepted), then req1 reads 0x10 the next cycle -> req_ready[1]=1; the following cycle rsp_valid=2'b10, rsp_data=0x5A.
- Req0 and req1 both continuously read 0x00/0x01 holding 0xAA/0xBB -> grants alternate 0,1,0,1; responses are tagged correctly, with one per cycle.
- Same cycle: req0 writes 0x33 to 0x20 and req1 reads 0x20 (old 0x11) -> write accepted, read stalled one cycle, then rsp_data=0x33; never 0x11.
- Same cycle: req0 writes 0x44 to 0x30 and req1 reads 0x31 (=0x77) -> both ready the same cycle; rsp_data=0x77 in T+1.
- Read granted in T, rst_n pulsed low mid-T -> no rsp_valid in T+1, rd_ptr=0, and the RAM contents written before reset are preserved.
